acap_mailbox_ctrl: RTL and testbench
====================================

ACAP_MAILBOX_CTRL -- requirements
Module: acap_mailbox_ctrl

Interface
REQ-001 Parameter START_ADDR, default 32'h1004: BRAM word address of the host start mailbox.
REQ-002 Parameter DONE_ADDR, default 32'h1789: BRAM word address of the completion mailbox.
REQ-003 Parameter START_MAGIC, default 32'hdeadbeef: start value written by the host.
REQ-004 Parameter DONE_MAGIC, default 32'hd01ecafe: completion value written by the block.
REQ-005 Parameter ERR_MAGIC, default 32'hbad0cafe: timeout value written by the block.
REQ-006 Parameter POLL_GAP, default 16: idle cycles between mailbox polls.
REQ-007 Parameter TIMEOUT_CYC, default 200000: maximum RUN cycles before abort.
REQ-008 clk  in  1  single clock; all logic rising-edge.
REQ-009 resetn  in  1  asynchronous, active-low reset.
REQ-010 ctrl_en  in  1  1 = polling allowed; 0 = finish current job, then hold in IDLE.
REQ-011 bram_addr / bram_wdata  out  32 / 32  shared BRAM port address / write data.
REQ-012 bram_we  out  4  byte write enables (4'b1111 or 4'b0000 only).
REQ-013 bram_rdata  in  32  BRAM read data, valid one cycle after address.
REQ-014 core_addr / core_wdata / core_we  in  32 / 32 / 4  accumulator-core port request.
REQ-015 core_rdata  out  32  bram_rdata forwarded unregistered to the core.
REQ-016 core_start  out  1  one-cycle start pulse to the core.
REQ-017 core_done  in  1  core completion level/pulse.
REQ-018 busy / err  out  1 / 1  job in progress / sticky timeout flag.
REQ-019 job_count  out  16  completed jobs, wraps at 16'hffff -> 0.

Function
REQ-020 FSM states SHALL be IDLE, POLL_RD, POLL_CHK, CLR_START, CLR_DONE, START, RUN, DONE_WR, GAP.
REQ-021 IDLE -> POLL_RD when ctrl_en=1; otherwise stay.
REQ-022 POLL_RD: drive bram_addr=START_ADDR, we=0, one cycle -> POLL_CHK.
REQ-023 POLL_CHK: bram_rdata==START_MAGIC -> CLR_START; else -> GAP.
REQ-024 GAP: count POLL_GAP cycles, then -> POLL_RD if ctrl_en else IDLE.
REQ-025 CLR_START: write 32'h0 to START_ADDR (we=4'b1111), one cycle -> CLR_DONE.
REQ-026 CLR_DONE: write 32'h0 to DONE_ADDR, one cycle -> START.
REQ-027 START: core_start=1 for exactly this cycle, clear timeout counter -> RUN.
REQ-028 RUN: BRAM port muxed to core_addr/core_wdata/core_we combinationally; exit on core_done=1 -> DONE_WR.
REQ-029 Outside RUN, core requests SHALL be ignored: bram signals driven by the FSM, core_we never reaches BRAM.
REQ-030 RUN timeout: counter reaching TIMEOUT_CYC-1 without core_done -> set err, write ERR_MAGIC to DONE_ADDR, -> IDLE.
REQ-031 core_done and timeout in the same cycle: core_done wins.
REQ-032 DONE_WR: write DONE_MAGIC to DONE_ADDR, job_count+1 -> GAP.
REQ-033 core_done outside RUN SHALL be ignored.
REQ-034 busy=1 in states CLR_START through DONE_WR inclusive, else 0.
REQ-035 err cleared only by reset; a set err does not block further jobs.
REQ-036 Minimum latency: START_MAGIC visible in bram_rdata during POLL_CHK -> core_start 3 cycles later.
REQ-037 ctrl_en deassertion during a job SHALL NOT abort it.

Reset
REQ-038 resetn=0 asynchronously forces IDLE, bram_addr=0, bram_wdata=0, bram_we=0, core_start=0, busy=0, err=0, job_count=0, all counters 0.
REQ-039 Reset mid-RUN abandons the job; no mailbox write follows reset release until a new poll hit.

Structure
REQ-040 Mailbox addresses, magic words, and the FSM state encoding SHALL live in a shared package (defines file) alongside DATA_SIZE_ARB/RING_SIZE.
REQ-041 Timeout and gap counting SHALL use one sub-module, cycle_counter (load, enable, terminal-count flag).

Verification
REQ-042 Behavioural BRAM model with 1-cycle read; host writes 32'hdeadbeef at 32'h1004 -> START_ADDR reads 0, core_start pulses once, core model done after 500 cycles -> 32'h1789 reads 32'hd01ecafe, job_count=1.
REQ-043 Mailbox holds 32'hdeadbe3f -> no core_start over 10 polls, spacing POLL_GAP+2 cycles between reads.
REQ-044 Core never asserts done, TIMEOUT_CYC=1000 -> 32'h1789 reads 32'hbad0cafe, err=1, state IDLE.
REQ-045 Core attempts write 32'h55 to 32'h1800 during GAP -> BRAM unchanged; same write in RUN -> stored.
REQ-046 resetn pulsed low mid-RUN -> all outputs 0 immediately; next job after new 32'hdeadbeef completes normally.
REQ-047 core_done and timeout coincide -> DONE_MAGIC written, err stays 0.

Source files
------------

// File: rtl/acap_mailbox_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// acap_mailbox_ctrl_pkg
// Shared definitions for the mailbox controller: default mailbox addresses,
// magic words, timing defaults, accumulator data sizing and the FSM state
// encoding. No ports; imported by the controller and its bench.
// -----------------------------------------------------------------------------
package acap_mailbox_ctrl_pkg;

  // Accumulator data region and descriptor ring sizing (words / entries).
  localparam int DATA_SIZE_ARB = 1024;
  localparam int RING_SIZE     = 16;

  // Default mailbox locations (BRAM word addresses) and handshake values.
  localparam logic [31:0] MB_START_ADDR   = 32'h0000_1004;
  localparam logic [31:0] MB_DONE_ADDR    = 32'h0000_1789;
  localparam logic [31:0] MB_START_MAGIC  = 32'hdead_beef;
  localparam logic [31:0] MB_DONE_MAGIC   = 32'hd01e_cafe;
  localparam logic [31:0] MB_ERR_MAGIC    = 32'hbad0_cafe;

  // Default timing.
  localparam int MB_POLL_GAP    = 16;
  localparam int MB_TIMEOUT_CYC = 200000;

  // Byte-enable patterns; the BRAM port only ever sees whole-word writes.
  localparam logic [3:0] WE_ALL  = 4'b1111;
  localparam logic [3:0] WE_NONE = 4'b0000;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    POLL_RD   = 4'd1,
    POLL_CHK  = 4'd2,
    CLR_START = 4'd3,
    CLR_DONE  = 4'd4,
    START     = 4'd5,
    RUN       = 4'd6,
    DONE_WR   = 4'd7,
    GAP       = 4'd8
  } mb_state_e;

  // A job is in progress from clearing the start mailbox up to and
  // including the completion write.
  function automatic logic state_is_busy(input mb_state_e s);
    case (s)
      CLR_START, CLR_DONE, START, RUN, DONE_WR: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/acap_mailbox_ctrl_cycle_counter.sv
// -----------------------------------------------------------------------------
// cycle_counter
// Loadable down-counter with a terminal-count flag. Used for both the poll
// gap and the RUN timeout (the two never overlap).
// Ports:
//   clk       in   clock, rising edge
//   resetn    in   asynchronous active-low reset (count -> 0)
//   load      in   load load_val this cycle (has priority over en)
//   load_val  in   WIDTH value to load
//   en        in   decrement by one while the count is non-zero
//   tc        out  count is zero
// -----------------------------------------------------------------------------
module cycle_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/acap_mailbox_ctrl.sv
// -----------------------------------------------------------------------------
// acap_mailbox_ctrl
// Polls a host start mailbox in BRAM, launches the accumulator core, hands
// the BRAM port to the core while it runs, then posts a completion (or
// timeout) word to the done mailbox.
// Ports:
//   clk, resetn                 clock / asynchronous active-low reset
//   ctrl_en                     1 = polling allowed, 0 = finish job then idle
//   bram_addr/wdata/we          shared BRAM port (we is 4'hf or 4'h0)
//   bram_rdata                  BRAM read data, one cycle after address
//   core_addr/wdata/we          core request, reaches BRAM only in RUN
//   core_rdata                  bram_rdata forwarded to the core
//   core_start / core_done      one-cycle launch pulse / completion
//   busy / err / job_count      job active / sticky timeout / completed jobs
// -----------------------------------------------------------------------------
module acap_mailbox_ctrl
  import acap_mailbox_ctrl_pkg::*;
#(
  parameter logic [31:0] START_ADDR  = MB_START_ADDR,
  parameter logic [31:0] DONE_ADDR   = MB_DONE_ADDR,
  parameter logic [31:0] START_MAGIC = MB_START_MAGIC,
  parameter logic [31:0] DONE_MAGIC  = MB_DONE_MAGIC,
  parameter logic [31:0] ERR_MAGIC   = MB_ERR_MAGIC,
  parameter int          POLL_GAP    = MB_POLL_GAP,
  parameter int          TIMEOUT_CYC = MB_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ctrl_en,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  output logic [3:0]  bram_we,
  input  logic [31:0] bram_rdata,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_we,
  output logic [31:0] core_rdata,
  output logic        core_start,
  input  logic        core_done,
  output logic        busy,
  output logic        err,
  output logic [15:0] job_count
);

  // The counter runs down to zero, so a load of N-1 gives N cycles.
  localparam logic [31:0] GAP_LOAD     = 32'(POLL_GAP - 1);
  localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYC - 1);

  mb_state_e   state_reg, state_next;
  logic        err_reg;
  logic [15:0] job_count_reg;

  logic        cnt_load, cnt_en, cnt_tc;
  logic [31:0] cnt_load_val;
  logic        set_err, inc_job;

  cycle_counter #(.WIDTH(32)) u_cycle_counter (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_next   = state_reg;
    bram_addr    = '0;
    bram_wdata   = '0;
    bram_we      = WE_NONE;
    core_start   = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = GAP_LOAD;
    cnt_en       = 1'b0;
    set_err      = 1'b0;
    inc_job      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (ctrl_en) state_next = POLL_RD;
      end
      POLL_RD: begin
        bram_addr  = START_ADDR;
        state_next = POLL_CHK;
      end
      POLL_CHK: begin
        if (bram_rdata == START_MAGIC) begin
          state_next = CLR_START;
        end else begin
          cnt_load   = 1'b1;
          state_next = GAP;
        end
      end
      CLR_START: begin
        bram_addr  = START_ADDR;
        bram_we    = WE_ALL;
        state_next = CLR_DONE;
      end
      CLR_DONE: begin
        bram_addr  = DONE_ADDR;
        bram_we    = WE_ALL;
        state_next = START;
      end
      START: begin
        core_start   = 1'b1;
        cnt_load     = 1'b1;
        cnt_load_val = TIMEOUT_LOAD;
        state_next   = RUN;
      end
      RUN: begin
        // Core owns the port; partial byte enables are dropped so the BRAM
        // only ever sees whole-word writes.
        bram_addr  = core_addr;
        bram_wdata = core_wdata;
        bram_we    = (core_we == WE_ALL) ? WE_ALL : WE_NONE;
        cnt_en     = 1'b1;
        if (core_done) begin
          state_next = DONE_WR;
        end else if (cnt_tc) begin
          // Abort: the error word replaces the core's request this cycle.
          bram_addr  = DONE_ADDR;
          bram_wdata = ERR_MAGIC;
          bram_we    = WE_ALL;
          set_err    = 1'b1;
          state_next = IDLE;
        end
      end
      DONE_WR: begin
        bram_addr  = DONE_ADDR;
        bram_wdata = DONE_MAGIC;
        bram_we    = WE_ALL;
        inc_job    = 1'b1;
        cnt_load   = 1'b1;
        state_next = GAP;
      end
      GAP: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_next = ctrl_en ? POLL_RD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      err_reg       <= 1'b0;
      job_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (set_err) err_reg <= 1'b1;
      if (inc_job) job_count_reg <= job_count_reg + 16'd1;
    end
  end

  assign core_rdata = bram_rdata;
  assign busy       = state_is_busy(state_reg);
  assign err        = err_reg;
  assign job_count  = job_count_reg;

endmodule

// File: tb/tb_acap_mailbox_ctrl.sv
`timescale 1ns/1ps
module tb_acap_mailbox_ctrl;

  localparam int          T_CYC    = 1000;
  localparam int          GAP_CYC  = 16;
  localparam logic [31:0] A_START  = 32'h1004;
  localparam logic [31:0] A_DONE   = 32'h1789;
  localparam logic [31:0] M_START  = 32'hdeadbeef;
  localparam logic [31:0] M_DONE   = 32'hd01ecafe;
  localparam logic [31:0] M_ERR    = 32'hbad0cafe;

  logic        clk = 1'b0;
  logic        resetn, ctrl_en;
  logic [31:0] bram_addr, bram_wdata, bram_rdata;
  logic [3:0]  bram_we, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_start, core_done, busy, err;
  logic [15:0] job_count;

  always #5 clk = ~clk;

  acap_mailbox_ctrl #(.POLL_GAP(GAP_CYC), .TIMEOUT_CYC(T_CYC)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ctrl_en    (ctrl_en),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_we    (bram_we),
    .bram_rdata (bram_rdata),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_we    (core_we),
    .core_rdata (core_rdata),
    .core_start (core_start),
    .core_done  (core_done),
    .busy       (busy),
    .err        (err),
    .job_count  (job_count)
  );

  // Behavioural BRAM: one-cycle registered read, host backdoor port.
  logic [31:0] mem [0:8191];
  logic        mem_clear, host_wr;
  logic [31:0] host_addr, host_data;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 8192; i++) mem[i] <= '0;
    end else if (bram_we == 4'hf) begin
      mem[bram_addr[12:0]] <= bram_wdata;
    end else if (host_wr) begin
      mem[host_addr[12:0]] <= host_data;
    end
    bram_rdata <= mem[bram_addr[12:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state.
  logic [31:0] exp_mem [0:8191];
  logic [15:0] exp_jobs;
  logic        exp_err;
  int          exp_starts;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [12:0] idx(input logic [31:0] a);
    return a[12:0];
  endfunction

  // Monitor: poll reads, start pulses, start latency, legal byte enables.
  int last_poll = -100;
  int start_cnt = 0;
  int poll_q[$];

  always @(negedge clk) begin
    if (resetn) begin
      chk("we_legal", 32'(bram_we == 4'h0 || bram_we == 4'hf), 32'd1);
      if (bram_we == 4'h0 && bram_addr == A_START) begin
        last_poll = cyc;
        poll_q.push_back(cyc);
      end
      if (core_start) begin
        start_cnt++;
        chk("start_latency", 32'(cyc - last_poll), 32'd4);
      end
    end
  end

  task automatic host_post(input logic [31:0] d);
    @(negedge clk);
    host_addr = A_START;
    host_data = d;
    host_wr   = 1'b1;
    @(negedge clk);
    host_wr = 1'b0;
    exp_mem[idx(A_START)] = d;
  endtask

  task automatic wait_start(output bit seen);
    int waited;
    waited = 0;
    while (!core_start && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    seen = core_start;
    chk("start_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_mailboxes(input string tag);
    chk({tag, "_start_mb"}, mem[idx(A_START)], exp_mem[idx(A_START)]);
    chk({tag, "_done_mb"},  mem[idx(A_DONE)],  exp_mem[idx(A_DONE)]);
    chk({tag, "_jobs"},     32'(job_count),    32'(exp_jobs));
    chk({tag, "_err"},      32'(err),          32'(exp_err));
  endtask

  // One host-triggered job; the core finishes after lat RUN cycles and
  // writes randomly into 0x1800..0x18ff on the way.
  task automatic run_job(input int lat, input bit force55, input bit drop_en);
    bit          seen, wr, done_ok;
    logic [31:0] a, d;
    ctrl_en = 1'b1;
    host_post(M_START);
    wait_start(seen);
    if (!seen) return;
    chk("busy_at_start", 32'(busy), 32'd1);
    if (drop_en) ctrl_en = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (k == lat) begin
        core_we   = 4'h0;
        core_done = 1'b1;
      end else begin
        wr = (force55 && k == 0) || ($urandom_range(0, 3) == 0);
        a  = (force55 && k == 0) ? 32'h1800 : 32'h1800 + 32'($urandom_range(0, 255));
        d  = (force55 && k == 0) ? 32'h55 : $urandom;
        core_addr  = a;
        core_wdata = d;
        core_we    = wr ? 4'hf : 4'h0;
        // Core writes land only while it owns the port; the last timeout
        // cycle carries the error word instead.
        if (wr && k < T_CYC - 1) exp_mem[idx(a)] = d;
        if (k == 3 && lat > 10) chk("busy_in_run", 32'(busy), 32'd1);
      end
    end
    @(negedge clk);
    core_done = 1'b0;
    core_we   = 4'h0;
    done_ok = (lat <= T_CYC - 1);
    exp_mem[idx(A_START)] = '0;
    exp_mem[idx(A_DONE)]  = done_ok ? M_DONE : M_ERR;
    if (done_ok) exp_jobs = exp_jobs + 16'd1;
    else         exp_err  = 1'b1;
    exp_starts++;
    repeat (4) @(negedge clk);
    check_mailboxes(done_ok ? "job" : "timeout");
    chk("start_count", 32'(start_cnt), 32'(exp_starts));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},  bram_addr,        32'd0);
    chk({tag, "_wdata"}, bram_wdata,       32'd0);
    chk({tag, "_we"},    32'(bram_we),     32'd0);
    chk({tag, "_start"}, 32'(core_start),  32'd0);
    chk({tag, "_busy"},  32'(busy),        32'd0);
    chk({tag, "_err"},   32'(err),         32'd0);
    chk({tag, "_jobs"},  32'(job_count),   32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit seen;
    core_addr = '0; core_wdata = '0; core_we = '0; core_done = 1'b0;
    host_wr = 1'b0; host_addr = '0; host_data = '0; mem_clear = 1'b1;
    resetn = 1'b0; ctrl_en = 1'b0;
    exp_jobs = '0; exp_err = 1'b0; exp_starts = 0;
    for (int i = 0; i < 8192; i++) exp_mem[i] = '0;

    repeat (3) @(negedge clk);
    mem_clear = 1'b0;
    check_reset_outputs("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_poll", bram_addr, 32'd0);

    // Near-miss magic: polls only, fixed spacing; core writes stay out.
    host_post(32'hdeadbe3f);
    poll_q.delete();
    core_addr = 32'h1800; core_wdata = 32'h55; core_we = 4'hf;
    ctrl_en = 1'b1;
    repeat (11 * (GAP_CYC + 2) + 5) @(negedge clk);
    core_we = 4'h0;
    chk("poll_count", 32'(poll_q.size() >= 11), 32'd1);
    for (int i = 1; i <= 10 && i < poll_q.size(); i++)
      chk("poll_spacing", 32'(poll_q[i] - poll_q[i-1]), 32'(GAP_CYC + 2));
    chk("no_start_on_miss", 32'(start_cnt), 32'd0);
    chk("gap_write_blocked", mem[idx(32'h1800)], 32'd0);
    chk("miss_mailbox_kept", mem[idx(A_START)], 32'hdeadbe3f);

    // First job: 500-cycle core, 0x55 to 0x1800 while running.
    run_job(500, 1'b1, 1'b0);
    chk("run_write_stored", mem[idx(32'h1800)], 32'h55);

    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(1, 300)), 1'b0, 1'($urandom_range(0, 1)));

    // core_done on the timeout cycle: completion wins.
    run_job(T_CYC - 1, 1'b0, 1'b0);

    // Timeout with ctrl_en dropped: error word, sticky err, back to IDLE.
    run_job(T_CYC + 30, 1'b0, 1'b1);
    chk("timeout_idle_addr", bram_addr, 32'd0);
    chk("timeout_idle_busy", 32'(busy), 32'd0);

    // err does not block another job.
    run_job(50, 1'b0, 1'b0);

    // Reset while the core is writing in RUN.
    ctrl_en = 1'b1;
    host_post(M_START);
    wait_start(seen);
    if (seen) exp_starts++;
    @(negedge clk);
    core_addr = 32'h18ff; core_wdata = 32'hcafe0001; core_we = 4'hf;
    exp_mem[idx(32'h18ff)] = 32'hcafe0001;
    repeat (100) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    core_we = 4'h0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    exp_jobs = '0;
    exp_err  = 1'b0;
    exp_mem[idx(A_START)] = '0;
    exp_mem[idx(A_DONE)]  = '0;
    repeat (60) @(negedge clk);
    check_mailboxes("after_reset");

    run_job(80, 1'b0, 1'b0);

    for (int i = 32'h1800; i < 32'h1900; i++)
      chk("mem_window", mem[i], exp_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
